inst_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one execution slot among the sibling sub-module instances of a generated root module (five instances by default). Each instance raises a request, gets an exclusive one-hot grant, and holds it until it signals done or a watchdog expires. The block sits beside the instances in the parent module. It is the only source of their enable/grant lines.

---
 rtl/inst_rr_scheduler.sv | 176 +++++++++++++++++
 tb/tb_inst_rr_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rr_scheduler.sv
// ----------------------------------------------------------------------------
// inst_rr_scheduler
//
// Round-robin scheduler that shares one execution slot among N sibling
// instances. A requester gets an exclusive one-hot grant and keeps it until
// it pulses its own done bit, or, when the watchdog is built in, until the
// grant has lasted TMO_CYC cycles. After every grant the scheduler spends
// one cycle in IDLE. The released holder then becomes the lowest priority.
//
// Optional feature macro: WATCHDOG_EN
//   defined   : the grant-length counter, forced release and tmo pulse exist
//   undefined : no counter logic; a grant ends only on done; tmo is tied to 0
//
// Parameters:
//   N       - number of requesting instances (2..16)
//   TMO_W   - width of the watchdog counter
//   TMO_CYC - grant cycles before forced release (TMO_CYC-1 must fit TMO_W)
//
// Ports:
//   clk    in   1          single clock, rising edge
//   rst_n  in   1          asynchronous active-low reset
//   req    in   N          per-instance request level
//   done   in   N          per-instance completion pulse (holder's bit only)
//   gnt    out  N          registered one-hot grant, zero when idle
//   gnt_id out  clog2(N)   index of the current holder, 0 when idle
//   busy   out  1          high while a grant is asserted
//   tmo    out  1          one-cycle pulse on a forced release
// ----------------------------------------------------------------------------
module inst_rr_scheduler #(
    parameter int N       = 5,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 tmo
);

    localparam int             IDW     = $clog2(N);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);
    localparam logic [N-1:0]   ONE     = N'(1);

    // Elaboration-time sanity checks on the configuration.
    if (N < 2 || N > 16) begin : g_chk_n
        $error("inst_rr_scheduler: N must lie in 2..16");
    end
    if (TMO_CYC < 1 || TMO_CYC > (1 << TMO_W)) begin : g_chk_tmo
        $error("inst_rr_scheduler: TMO_CYC must be >= 1 and TMO_CYC-1 must fit TMO_W");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;        // highest-priority index for the next pick
    logic           sel_valid;
    logic [IDW-1:0] sel_id;
    logic [IDW-1:0] next_ptr;
    logic           holder_done;

    // ------------------------------------------------------------------
    // Request selection: every candidate gets its distance from ptr in
    // the circular scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the requesting
    // candidate with the smallest distance wins. Looping over constant
    // candidate indices keeps every bit select static.
    // ------------------------------------------------------------------
    always_comb begin
        int off;
        int best;
        off       = 0;
        best      = N;
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int c = 0; c < N; c++) begin
            if (c >= int'(ptr)) begin
                off = c - int'(ptr);
            end else begin
                off = c + N - int'(ptr);
            end
            if (req[c] && (off < best)) begin
                best      = off;
                sel_valid = 1'b1;
                sel_id    = IDW'(c);
            end
        end
    end

    // The holder's done is found by masking with the one-hot grant, which
    // ignores foreign done bits and all done bits while idle (gnt == 0).
    assign holder_done = |(done & gnt);

    // After release the holder drops to lowest priority.
    assign next_ptr = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;

`ifdef WATCHDOG_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] wd_cnt;
    logic             wd_expire;

    assign wd_expire = (wd_cnt == TMO_LAST);
`else
    // Without the watchdog a grant can only end on done.
    assign tmo = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scheduler state machine; all outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= '0;
`ifdef WATCHDOG_EN
            wd_cnt <= '0;
            tmo    <= 1'b0;
`endif
        end else begin
`ifdef WATCHDOG_EN
            tmo <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state  <= GRANT;
                        gnt    <= ONE << sel_id;
                        gnt_id <= sel_id;
                        busy   <= 1'b1;
`ifdef WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end

                GRANT: begin
                    // done takes precedence over a coincident expiry, so
                    // a simultaneous done/expiry never raises tmo.
                    if (holder_done) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                        ptr    <= next_ptr;
                    end
`ifdef WATCHDOG_EN
                    else if (wd_expire) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                        ptr    <= next_ptr;
                        tmo    <= 1'b1;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// ----------------------------------------------------------------------------
// Testbench for inst_rr_scheduler (default parameters N=5, TMO_CYC=200).
// A directed vector table, hand-written multi-cycle sequences and a random
// phase checked against a behavioural model of the scheduling rules.
// ----------------------------------------------------------------------------
module tb_inst_rr_scheduler;

    localparam int N       = 5;
    localparam int TMO_W   = 8;
    localparam int TMO_CYC = 200;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         busy;
    logic         tmo;

    int checks;
    int errors;

    // Behavioural model state: holder index (-1 when idle), priority pointer,
    // cycles the current grant has lasted, and the expected tmo pulse.
    int m_holder;
    int m_ptr;
    int m_cnt;
    int m_tmo;

    inst_rr_scheduler #(
        .N      (N),
        .TMO_W  (TMO_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .busy  (busy),
        .tmo   (tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] gnt;
        logic [2:0]   id;
        logic         busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic [N-1:0] e_gnt,
                              input logic [2:0] e_id, input logic e_busy, input logic e_tmo);
        check({name, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({name, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
        check({name, ".busy"}, 32'(busy), 32'(e_busy));
        check({name, ".tmo"}, 32'(tmo), 32'(e_tmo));
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_tmo    = 0;
    endfunction

    // One clock edge of the scheduling rules, using the inputs seen at it.
    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit wd;
`ifdef WATCHDOG_EN
        wd = 1'b1;
`else
        wd = 1'b0;
`endif
        m_tmo = 0;
        if (m_holder < 0) begin
            if (r != '0) begin
                m_holder = pick(r, m_ptr);
                m_cnt    = 1;
            end
        end else if (d[m_holder]) begin
            m_ptr    = (m_holder + 1) % N;
            m_holder = -1;
        end else if (wd && m_cnt >= TMO_CYC) begin
            m_ptr    = (m_holder + 1) % N;
            m_holder = -1;
            m_tmo    = 1;
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic check_model(input string name);
        logic [N-1:0] e_gnt;
        logic [2:0]   e_id;
        e_gnt = (m_holder < 0) ? '0 : (N'(1) << m_holder);
        e_id  = (m_holder < 0) ? 3'd0 : 3'(m_holder);
        check_outs(name, e_gnt, e_id, m_holder >= 0, m_tmo[0]);
    endtask

    // Apply current inputs across one rising edge and update the model.
    task automatic cycle();
        @(posedge clk);
        model_step(req, done);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    vec_t vecs[17];
    int   cnt_hi;
    bit   seen_tmo;

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        // Directed vectors, starting from reset (ptr = 0).
        vecs[0]  = '{5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1};
        vecs[1]  = '{5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1};
        vecs[2]  = '{5'b00000, 5'b00000, 5'b00100, 3'd2, 1'b1};
        vecs[3]  = '{5'b00000, 5'b00001, 5'b00100, 3'd2, 1'b1};
        vecs[4]  = '{5'b00000, 5'b00100, 5'b00000, 3'd0, 1'b0};
        vecs[5]  = '{5'b00011, 5'b00100, 5'b00001, 3'd0, 1'b1};
        vecs[6]  = '{5'b00011, 5'b00010, 5'b00001, 3'd0, 1'b1};
        vecs[7]  = '{5'b00011, 5'b00001, 5'b00000, 3'd0, 1'b0};
        vecs[8]  = '{5'b00011, 5'b00000, 5'b00010, 3'd1, 1'b1};
        vecs[9]  = '{5'b00000, 5'b01000, 5'b00010, 3'd1, 1'b1};
        vecs[10] = '{5'b00000, 5'b00010, 5'b00000, 3'd0, 1'b0};
        vecs[11] = '{5'b00011, 5'b00000, 5'b00001, 3'd0, 1'b1};
        vecs[12] = '{5'b00000, 5'b00001, 5'b00000, 3'd0, 1'b0};
        vecs[13] = '{5'b10000, 5'b00000, 5'b10000, 3'd4, 1'b1};
        vecs[14] = '{5'b00000, 5'b10000, 5'b00000, 3'd0, 1'b0};
        vecs[15] = '{5'b10001, 5'b00000, 5'b00001, 3'd0, 1'b1};
        vecs[16] = '{5'b00000, 5'b00001, 5'b00000, 3'd0, 1'b0};

        // Reset and idle: outputs at reset values during and after reset.
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        #2;
        check_outs("reset_async", '0, 3'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_held", '0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_outs("idle", '0, 3'd0, 1'b0, 1'b0);
        end

        // Vector table.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, 1'b0);
        end

        // Fairness: all requesting, each holder keeps the grant 2 cycles.
        do_reset();
        req = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            done = '0;
            cycle();
            check_outs($sformatf("fair_g%0d_a", g), 5'(1 << (g % N)), 3'(g % N), 1'b1, 1'b0);
            cycle();
            check_outs($sformatf("fair_g%0d_b", g), 5'(1 << (g % N)), 3'(g % N), 1'b1, 1'b0);
            done = 5'(1 << (g % N));
            cycle();
            check_outs($sformatf("fair_idle%0d", g), '0, 3'd0, 1'b0, 1'b0);
        end
        done = '0;

        // Long hold without done.
        do_reset();
        req      = 5'b00001;
        cnt_hi   = 0;
        seen_tmo = 1'b0;
        cycle();
        while (gnt == 5'b00001 && cnt_hi < 300) begin
            cnt_hi++;
            if (tmo) seen_tmo = 1'b1;
            cycle();
        end
`ifdef WATCHDOG_EN
        check("wd_hold_len", 32'(cnt_hi), 32'(TMO_CYC));
        check("wd_tmo_pulse", 32'(tmo), 32'd1);
        check("wd_no_early_tmo", 32'(seen_tmo), 32'd0);
        req = 5'b01001;
        cycle();
        check_outs("wd_next", 5'b01000, 3'd3, 1'b1, 1'b0);
`else
        check("nowd_hold_len", 32'(cnt_hi), 32'd300);
        check("nowd_no_tmo", 32'(seen_tmo), 32'd0);
        check_outs("nowd_still", 5'b00001, 3'd0, 1'b1, 1'b0);
`endif
        req  = '0;
        done = 5'b11111;
        cycle();
        done = '0;

        // Asynchronous reset mid-grant restores ptr to 0.
        do_reset();
        req = 5'b00010;
        cycle();
        done = 5'b00010;
        cycle();
        done = '0;
        req  = 5'b01000;
        cycle();
        check_outs("ar_pre", 5'b01000, 3'd3, 1'b1, 1'b0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("ar_drop", '0, 3'd0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_outs("ar_held", '0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 5'b01001;
        cycle();
        check_outs("ar_ptr0", 5'b00001, 3'd0, 1'b1, 1'b0);

        // Random phase against the behavioural model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int mode;
            mode = (i / 500) % 4;
            req  = N'($urandom);
            if (mode == 0) req = '0 | N'($urandom_range(0, 1) << $urandom_range(0, N - 1));
            case (mode)
                0, 1:    done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                2:       done = N'($urandom);
                default: done = ($urandom_range(0, 299) == 0) ? N'($urandom) : '0;
            endcase
            cycle();
            check_model($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
